level_meter: RTL and testbench



---
 rtl/meter_pkg.sv | 28 ++
 rtl/level_meter_update.sv | 51 +++++
 rtl/level_meter.sv | 129 ++++++++++++
 tb/tb_level_meter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
// Shared types and helpers for the per-channel level meter.
package meter_pkg;

  localparam int DATA_W = 24;
  localparam int MAG_W  = 23;
  localparam logic [MAG_W-1:0] FULL_SCALE = 23'h7F_FFFF;

  typedef logic [MAG_W-1:0] mag_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // |x| with the single negative code that has no positive twin pinned to full scale.
  function automatic mag_t sat_abs(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    neg = -x;
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
      return FULL_SCALE;
    end else if (x[DATA_W-1]) begin
      return neg[MAG_W-1:0];
    end else begin
      return x[MAG_W-1:0];
    end
  endfunction

endpackage

// File: rtl/level_meter_update.sv
// Combinational next-state for one meter channel: peak/hold/decay and clip hold.
module level_meter_update
  import meter_pkg::*;
#(
  parameter int HOLD_FRAMES      = 24000,
  parameter int DECAY_SHIFT      = 10,
  parameter int CLIP_HOLD_FRAMES = 48000,
  parameter int HOLD_W           = 15,
  parameter int CLIP_W           = 16
) (
  input  logic [MAG_W-1:0]  mag,
  input  logic              clip_flag,
  input  logic [MAG_W-1:0]  peak,
  input  logic [HOLD_W-1:0] hold,
  input  logic [CLIP_W-1:0] clip_cnt,
  output logic [MAG_W-1:0]  peak_next,
  output logic [HOLD_W-1:0] hold_next,
  output logic [CLIP_W-1:0] clip_cnt_next
);

  logic [MAG_W-1:0] decay;
  logic [MAG_W-1:0] decayed;

  always_comb begin
    decay = peak >> DECAY_SHIFT;
    if (decay == '0) begin
      decay = MAG_W'(1);
    end
    // Floor at zero so a tiny peak cannot underflow into a huge one.
    decayed = (peak > decay) ? (peak - decay) : '0;

    peak_next = peak;
    hold_next = hold;
    if (mag >= peak) begin
      peak_next = mag;
      hold_next = HOLD_W'(HOLD_FRAMES);
    end else if (hold != '0) begin
      hold_next = hold - HOLD_W'(1);
    end else begin
      peak_next = (mag > decayed) ? mag : decayed;
    end

    clip_cnt_next = clip_cnt;
    if (clip_flag || (mag == FULL_SCALE)) begin
      clip_cnt_next = CLIP_W'(CLIP_HOLD_FRAMES);
    end else if (clip_cnt != '0) begin
      clip_cnt_next = clip_cnt - CLIP_W'(1);
    end
  end

endmodule

// File: rtl/level_meter.sv
// Peak-hold level meter: captures a frame, then updates one channel per cycle
// and drives a 6 dB/step LED bar for the selected channel.
module level_meter
  import meter_pkg::*;
#(
  parameter int CHANNELS         = 8,
  parameter int HOLD_FRAMES      = 24000,
  parameter int DECAY_SHIFT      = 10,
  parameter int CLIP_HOLD_FRAMES = 48000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  input  logic [CHANNELS*DATA_W-1:0]    audio_in,
  input  logic [CHANNELS-1:0]           clip_in,
  input  logic [$clog2(CHANNELS)-1:0]   sel,
  output logic [CHANNELS*MAG_W-1:0]     peak_level,
  output logic [CHANNELS-1:0]           clip_led,
  output logic [7:0]                    led_bar,
  output logic                          frame_done,
  output logic                          overrun
);

  localparam int CH_W   = $clog2(CHANNELS);
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int CLIP_W = (CLIP_HOLD_FRAMES > 0) ? $clog2(CLIP_HOLD_FRAMES + 1) : 1;

  state_t            state;
  logic [CH_W-1:0]   ch;

  logic signed [DATA_W-1:0] frame_audio_p0 [CHANNELS];
  logic [CHANNELS-1:0]      frame_clip_p0;

  mag_t              peak_q [CHANNELS];
  logic [HOLD_W-1:0] hold_q [CHANNELS];
  logic [CLIP_W-1:0] clip_q [CHANNELS];

  mag_t              cur_mag_p1;
  mag_t              peak_nx;
  logic [HOLD_W-1:0] hold_nx;
  logic [CLIP_W-1:0] clip_nx;

  // Bar segment k lights once the magnitude reaches 2^(15+k).
  function automatic logic [7:0] bar_of(input mag_t p);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b[k] = (p >= (MAG_W'(1) << (15 + k)));
    end
    return b;
  endfunction

  // ---- stage p0: frame capture (data only, no reset) ----
  always_ff @(posedge clk) begin
    if ((state == IDLE) && sample_valid) begin
      for (int i = 0; i < CHANNELS; i++) begin
        frame_audio_p0[i] <= audio_in[i*DATA_W +: DATA_W];
      end
      frame_clip_p0 <= clip_in;
    end
  end

  // ---- stage p1: per-channel update of the channel under the cursor ----
  assign cur_mag_p1 = sat_abs(frame_audio_p0[ch]);

  level_meter_update #(
    .HOLD_FRAMES      (HOLD_FRAMES),
    .DECAY_SHIFT      (DECAY_SHIFT),
    .CLIP_HOLD_FRAMES (CLIP_HOLD_FRAMES),
    .HOLD_W           (HOLD_W),
    .CLIP_W           (CLIP_W)
  ) u_update (
    .mag           (cur_mag_p1),
    .clip_flag     (frame_clip_p0[ch]),
    .peak          (peak_q[ch]),
    .hold          (hold_q[ch]),
    .clip_cnt      (clip_q[ch]),
    .peak_next     (peak_nx),
    .hold_next     (hold_nx),
    .clip_cnt_next (clip_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      clip_led   <= '0;
      led_bar    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        peak_q[i] <= '0;
        hold_q[i] <= '0;
        clip_q[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      led_bar    <= bar_of(peak_q[sel]);
      case (state)
        IDLE: begin
          if (sample_valid) begin
            state <= RUN;
            ch    <= '0;
          end
        end
        RUN: begin
          if (sample_valid) begin
            overrun <= 1'b1;
          end
          peak_q[ch]   <= peak_nx;
          hold_q[ch]   <= hold_nx;
          clip_q[ch]   <= clip_nx;
          clip_led[ch] <= (clip_nx != '0);
          if (ch == CH_W'(CHANNELS - 1)) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            ch <= ch + CH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_peak_out
    assign peak_level[g*MAG_W +: MAG_W] = peak_q[g];
  end

endmodule

// File: tb/tb_level_meter.sv
// Directed bench for level_meter: vector table plus multi-frame corner sequences.
module tb_level_meter;

  localparam int CH = 8;
  localparam int HF = 4;
  localparam int DS = 10;
  localparam int CF = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            sample_valid;
  logic [CH*24-1:0] audio_in;
  logic [CH-1:0]   clip_in;
  logic [2:0]      sel;
  logic [CH*23-1:0] peak_level;
  logic [CH-1:0]   clip_led;
  logic [7:0]      led_bar;
  logic            frame_done;
  logic            overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  level_meter #(
    .CHANNELS         (CH),
    .HOLD_FRAMES      (HF),
    .DECAY_SHIFT      (DS),
    .CLIP_HOLD_FRAMES (CF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .clip_in      (clip_in),
    .sel          (sel),
    .peak_level   (peak_level),
    .clip_led     (clip_led),
    .led_bar      (led_bar),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  typedef struct {
    logic [23:0] sample;
    logic        clip;
    logic [22:0] exp_peak;
    logic [7:0]  exp_bar;
    logic        exp_clip;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] pk(input int i);
    return peak_level[i*23 +: 23];
  endfunction

  function automatic logic [CH*24-1:0] one_ch(input int i, input logic [23:0] v);
    logic [CH*24-1:0] a;
    a = '0;
    a[i*24 +: 24] = v;
    return a;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    audio_in = '0;
    clip_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge inside cycle T+start; returns n of the cycle T+n showing frame_done.
  task automatic wait_done(input int start, output int lat);
    lat = -1;
    for (int n = start; n <= 20; n++) begin
      if (frame_done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called at a negedge; that cycle is T. Returns at the negedge of the frame_done cycle.
  task automatic run_frame(input logic [CH*24-1:0] a, input logic [CH-1:0] c, output int lat);
    audio_in = a;
    clip_in = c;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_done(1, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;
    logic [CH*24-1:0] a;

    vecs[0]  = '{24'h400000, 1'b0, 23'h400000, 8'hFF, 1'b0};
    vecs[1]  = '{24'h800000, 1'b0, 23'h7FFFFF, 8'hFF, 1'b1};
    vecs[2]  = '{24'h7FFFFF, 1'b0, 23'h7FFFFF, 8'hFF, 1'b1};
    vecs[3]  = '{24'hFFFFFF, 1'b0, 23'h000001, 8'h00, 1'b0};
    vecs[4]  = '{24'h008000, 1'b0, 23'h008000, 8'h01, 1'b0};
    vecs[5]  = '{24'h007FFF, 1'b0, 23'h007FFF, 8'h00, 1'b0};
    vecs[6]  = '{24'hFF8000, 1'b0, 23'h008000, 8'h01, 1'b0};
    vecs[7]  = '{24'h0C0000, 1'b0, 23'h0C0000, 8'h1F, 1'b0};
    vecs[8]  = '{24'h200000, 1'b0, 23'h200000, 8'h7F, 1'b0};
    vecs[9]  = '{24'h000000, 1'b0, 23'h000000, 8'h00, 1'b0};
    vecs[10] = '{24'h001000, 1'b1, 23'h001000, 8'h00, 1'b1};

    rst = 1'b1;
    sample_valid = 1'b0;
    audio_in = '0;
    clip_in = '0;
    sel = 3'd0;

    do_reset();
    check("reset peak_level", {31'd0, |peak_level}, 32'd0);
    check("reset clip_led", {24'd0, clip_led}, 32'd0);
    check("reset led_bar", {24'd0, led_bar}, 32'd0);
    check("reset frame_done", {31'd0, frame_done}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);

    for (int v = 0; v < 11; v++) begin
      do_reset();
      sel = 3'd0;
      run_frame(one_ch(0, vecs[v].sample), {7'd0, vecs[v].clip}, lat);
      check($sformatf("vec%0d frame_done latency", v), lat, 32'd9);
      check($sformatf("vec%0d peak0", v), {9'd0, pk(0)}, {9'd0, vecs[v].exp_peak});
      check($sformatf("vec%0d clip_led0", v), {31'd0, clip_led[0]}, {31'd0, vecs[v].exp_clip});
      @(negedge clk);
      check($sformatf("vec%0d led_bar", v), {24'd0, led_bar}, {24'd0, vecs[v].exp_bar});
      check($sformatf("vec%0d frame_done pulse", v), {31'd0, frame_done}, 32'd0);
    end

    // Channel timing and sel switching.
    do_reset();
    sel = 3'd0;
    a = one_ch(0, 24'h400000) | one_ch(1, 24'h008000);
    audio_in = a;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("T+1 peak0 not yet", {9'd0, pk(0)}, 32'd0);
    @(negedge clk);
    check("T+2 peak0", {9'd0, pk(0)}, 32'h400000);
    check("T+2 peak1 not yet", {9'd0, pk(1)}, 32'd0);
    wait_done(2, lat);
    check("timing frame_done latency", lat, 32'd9);
    @(negedge clk);
    check("bar sel0", {24'd0, led_bar}, 32'hFF);
    sel = 3'd1;
    @(negedge clk);
    check("bar sel1", {24'd0, led_bar}, 32'h01);
    sel = 3'd0;

    // Clip hold on full-scale negative sample.
    do_reset();
    run_frame(one_ch(1, 24'h800000), '0, lat);
    check("clip peak1", {9'd0, pk(1)}, 32'h7FFFFF);
    check("clip led1 set", {31'd0, clip_led[1]}, 32'd1);
    for (int k = 1; k <= CF + 1; k++) begin
      run_frame('0, '0, lat);
      check($sformatf("clip led1 after %0d frames", k), {31'd0, clip_led[1]}, (k < CF) ? 32'd1 : 32'd0);
    end

    // Peak hold then decay.
    do_reset();
    run_frame(one_ch(2, 24'h100000), '0, lat);
    check("hold peak2 set", {9'd0, pk(2)}, 32'h100000);
    for (int k = 1; k <= HF; k++) begin
      run_frame('0, '0, lat);
      check($sformatf("hold peak2 frame %0d", k), {9'd0, pk(2)}, 32'h100000);
    end
    run_frame('0, '0, lat);
    check("decay peak2 first", {9'd0, pk(2)}, 32'h0FFC00);
    run_frame('0, '0, lat);
    check("decay peak2 second", {9'd0, pk(2)}, 32'h0FF801);

    // Minimum 1 LSB decay down to zero, no underflow.
    do_reset();
    run_frame(one_ch(3, 24'h000001), '0, lat);
    check("small peak3 set", {9'd0, pk(3)}, 32'd1);
    for (int k = 1; k <= HF; k++) begin
      run_frame('0, '0, lat);
      check($sformatf("small peak3 hold %0d", k), {9'd0, pk(3)}, 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      run_frame('0, '0, lat);
      check($sformatf("small peak3 zero %0d", k), {9'd0, pk(3)}, 32'd0);
    end

    // Overrun: second strobe during RUN is ignored.
    do_reset();
    audio_in = one_ch(4, 24'h001234);
    clip_in = '0;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    check("overrun before", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    audio_in = one_ch(4, 24'h7FFFFF);
    clip_in = '1;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_done(4, lat);
    check("overrun frame latency", lat, 32'd9);
    check("overrun peak4 from first", {9'd0, pk(4)}, 32'h001234);
    check("overrun clip_led", {24'd0, clip_led}, 32'd0);
    check("overrun set", {31'd0, overrun}, 32'd1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (frame_done) pulses++;
    end
    check("overrun no second frame", pulses, 32'd0);
    check("overrun sticky", {31'd0, overrun}, 32'd1);

    // Reset in the middle of a frame.
    do_reset();
    sel = 3'd0;
    a = '0;
    for (int i = 0; i < CH; i++) a[i*24 +: 24] = 24'h400000;
    audio_in = a;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst peak2 before", {9'd0, pk(2)}, 32'h400000);
    check("midrst bar before", {24'd0, led_bar}, 32'hFF);
    rst = 1'b1;
    @(negedge clk);
    check("midrst peak_level", {31'd0, |peak_level}, 32'd0);
    check("midrst clip_led", {24'd0, clip_led}, 32'd0);
    check("midrst led_bar", {24'd0, led_bar}, 32'd0);
    check("midrst frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    audio_in = '0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (frame_done) pulses++;
    end
    check("midrst no frame_done", pulses, 32'd0);
    run_frame(one_ch(5, 24'h000100), '0, lat);
    check("postrst latency", lat, 32'd9);
    check("postrst peak5", {9'd0, pk(5)}, 32'h000100);
    check("postrst peak0", {9'd0, pk(0)}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
